// File: rtl/nn_pkg.sv
// Shared types for the network output stages.
package nn_pkg;

  // Argmax collection FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StEval,
    StDone
  } state_e;

  // Default network value width, shared with the network tops.
  localparam int unsigned NnDw = 8;

  typedef logic signed [NnDw-1:0] nn_value_t;

endpackage

// File: rtl/nn_output_argmax_if.sv
// Serialized network output channel plus result handshake for the argmax stage.
interface nn_output_argmax_if
  import nn_pkg::*;
#(
  parameter int unsigned AW = 1,
  parameter int unsigned DW = NnDw
);
  logic                 start;
  logic                 out_valid;
  logic [AW-1:0]        out_addr;
  logic signed [DW-1:0] out_data;
  logic                 net_ack;
  logic                 res_valid;
  logic [AW-1:0]        res_class;
  logic signed [DW-1:0] res_value;
  logic                 res_err;
  logic                 res_ack;
  logic                 busy;

  // Network/consumer side.
  modport master (
    output start, out_valid, out_addr, out_data, net_ack, res_ack,
    input  res_valid, res_class, res_value, res_err, busy
  );

  // Argmax block side.
  modport slave (
    input  start, out_valid, out_addr, out_data, net_ack, res_ack,
    output res_valid, res_class, res_value, res_err, busy
  );
endinterface

// File: rtl/nn_max_cmp.sv
// Combinational signed compare-select: keeps the running best unless the
// candidate is strictly greater or no best exists yet.
module nn_max_cmp #(
  parameter int unsigned DW = 8,
  parameter int unsigned IW = 1
) (
  input  logic signed [DW-1:0] best_val_i,
  input  logic [IW-1:0]        best_idx_i,
  input  logic                 best_vld_i,
  input  logic signed [DW-1:0] cand_val_i,
  input  logic [IW-1:0]        cand_idx_i,
  output logic signed [DW-1:0] new_val_o,
  output logic [IW-1:0]        new_idx_o,
  output logic                 replace_o
);

  // Ties keep the earlier entry, so only a strict greater-than replaces.
  always_comb begin
    replace_o = !best_vld_i || (cand_val_i > best_val_i);
    new_val_o = replace_o ? cand_val_i : best_val_i;
    new_idx_o = replace_o ? cand_idx_i : best_idx_i;
  end

endmodule

// File: rtl/nn_output_argmax.sv
// Collects one inference's outputs and reports the winning class (argmax),
// or a threshold decision when the network has a single output.
module nn_output_argmax
  import nn_pkg::*;
#(
  parameter int unsigned        N_OUT  = 1,
  parameter int unsigned        DW     = NnDw,
  parameter int unsigned        AW     = 1,
  parameter logic signed [DW-1:0] THRESH = '0
) (
  input logic              clk_i,
  input logic              rst_ni,
  nn_output_argmax_if.slave bus
);

  localparam int unsigned CW = $clog2(N_OUT + 1);

  state_e               state_q, state_d;
  logic [N_OUT-1:0]     mask_q, mask_d;
  logic [CW-1:0]        count_q, count_d;
  logic signed [DW-1:0] best_val_q, best_val_d;
  logic [AW-1:0]        best_idx_q, best_idx_d;
  logic                 best_vld_q, best_vld_d;
  logic                 err_q, err_d;
  logic [AW-1:0]        res_class_q, res_class_d;
  logic signed [DW-1:0] res_value_q, res_value_d;
  logic                 res_err_q, res_err_d;

  logic [N_OUT-1:0]     hit;
  logic                 addr_ok, dup, clear;
  logic signed [DW-1:0] cmp_val;
  logic [AW-1:0]        cmp_idx;
  logic                 cmp_replace;

  // One-hot decode of the address; an all-zero result means out of range.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      hit[i] = (bus.out_addr == AW'(i));
    end
    addr_ok = |hit;
    dup     = |(hit & mask_q);
    clear   = bus.start && ((state_q == StIdle) || (state_q == StDone));
  end

  nn_max_cmp #(
    .DW(DW),
    .IW(AW)
  ) u_max_cmp (
    .best_val_i(best_val_q),
    .best_idx_i(best_idx_q),
    .best_vld_i(best_vld_q),
    .cand_val_i(bus.out_data),
    .cand_idx_i(bus.out_addr),
    .new_val_o (cmp_val),
    .new_idx_o (cmp_idx),
    .replace_o (cmp_replace)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; a start in DONE abandons the held result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.start) state_d = StCollect;
      StCollect: if (bus.net_ack) state_d = StEval;
      StEval:    state_d = StDone;
      StDone: begin
        if (bus.start)        state_d = StCollect;
        else if (bus.res_ack) state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.busy      = (state_q == StCollect);
    bus.res_valid = (state_q == StDone);
    bus.res_class = res_class_q;
    bus.res_value = res_value_q;
    bus.res_err   = res_err_q;
  end

  // Datapath next-state: collection bookkeeping and result latch in EVAL.
  always_comb begin
    mask_d      = mask_q;
    count_d     = count_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    best_vld_d  = best_vld_q;
    err_d       = err_q;
    res_class_d = res_class_q;
    res_value_d = res_value_q;
    res_err_d   = res_err_q;
    if (clear) begin
      mask_d     = '0;
      count_d    = '0;
      best_val_d = '0;
      best_idx_d = '0;
      best_vld_d = 1'b0;
      err_d      = 1'b0;
    end else if ((state_q == StCollect) && bus.out_valid) begin
      if (!addr_ok || dup) begin
        err_d = 1'b1;
      end else begin
        mask_d     = mask_q | hit;
        count_d    = count_q + CW'(1);
        best_val_d = cmp_val;
        best_idx_d = cmp_idx;
        best_vld_d = best_vld_q | cmp_replace;
      end
    end else if (state_q == StEval) begin
      res_value_d = best_val_q;
      res_err_d   = err_q | (count_q != CW'(N_OUT));
      if (N_OUT == 1) res_class_d = AW'(best_val_q >= THRESH);
      else            res_class_d = best_idx_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q      <= '0;
      count_q     <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      best_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      res_class_q <= '0;
      res_value_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      count_q     <= count_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      best_vld_q  <= best_vld_d;
      err_q       <= err_d;
      res_class_q <= res_class_d;
      res_value_q <= res_value_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_nn_output_argmax.sv
// Directed bench for nn_output_argmax: a 4-output argmax instance and a
// 1-output threshold instance on a shared clock.
module tb_nn_output_argmax;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nn_output_argmax_if #(.AW(3), .DW(8)) if4 ();
  nn_output_argmax_if #(.AW(1), .DW(8)) if1 ();

  nn_output_argmax #(
    .N_OUT (4),
    .DW    (8),
    .AW    (3),
    .THRESH(8'sd0)
  ) u_dut4 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if4)
  );

  nn_output_argmax #(
    .N_OUT (1),
    .DW    (8),
    .AW    (1),
    .THRESH(8'sd0)
  ) u_dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]        a_v [8];
  logic signed [7:0] d_v [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples them at the next rise.
  task automatic drive4(input logic st, input logic ov, input logic [2:0] a,
                        input logic signed [7:0] d, input logic nk, input logic rk);
    @(negedge clk);
    if4.start     = st;
    if4.out_valid = ov;
    if4.out_addr  = a;
    if4.out_data  = d;
    if4.net_ack   = nk;
    if4.res_ack   = rk;
  endtask

  task automatic drive1(input logic st, input logic ov, input logic signed [7:0] d,
                        input logic nk, input logic rk);
    @(negedge clk);
    if1.start     = st;
    if1.out_valid = ov;
    if1.out_addr  = 1'b0;
    if1.out_data  = d;
    if1.net_ack   = nk;
    if1.res_ack   = rk;
  endtask

  // Start, send n entries of a_v/d_v, then net_ack (merged with the last
  // entry when merge is set); checks the two-cycle result latency.
  task automatic infer4(input int n, input logic merge, input string tag);
    drive4(1'b1, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive4(1'b0, 1'b1, a_v[i], d_v[i], merge && (i == n - 1), 1'b0);
    end
    if (!merge) drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b1, 1'b0);
    drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    check_eq({tag, "_valid_eval"}, 32'(if4.res_valid), 32'd0);
    drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    check_eq({tag, "_valid_done"}, 32'(if4.res_valid), 32'd1);
  endtask

  task automatic ack4(input string tag);
    drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b1);
    drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    check_eq({tag, "_valid_after_ack"}, 32'(if4.res_valid), 32'd0);
  endtask

  task automatic infer1(input logic signed [7:0] d, input logic exp_cls, input string tag);
    drive1(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0);
    drive1(1'b0, 1'b1, d, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 8'sd0, 1'b1, 1'b0);
    drive1(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0);
    check_eq({tag, "_valid"}, 32'(if1.res_valid), 32'd1);
    check_eq({tag, "_class"}, 32'(if1.res_class), 32'(exp_cls));
    check_eq({tag, "_value"}, 32'(if1.res_value), 32'(d));
    check_eq({tag, "_err"}, 32'(if1.res_err), 32'd0);
    drive1(1'b0, 1'b0, 8'sd0, 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0);
  endtask

  task automatic load4(input logic [2:0] a0, a1, a2, a3, a4,
                       input logic signed [7:0] d0, d1, d2, d3, d4);
    a_v[0] = a0; a_v[1] = a1; a_v[2] = a2; a_v[3] = a3; a_v[4] = a4;
    d_v[0] = d0; d_v[1] = d1; d_v[2] = d2; d_v[3] = d3; d_v[4] = d4;
  endtask

  task automatic res4(input string tag, input logic [2:0] cls, input logic signed [7:0] val,
                      input logic err);
    check_eq({tag, "_class"}, 32'(if4.res_class), 32'(cls));
    check_eq({tag, "_value"}, 32'(if4.res_value), 32'(val));
    check_eq({tag, "_err"}, 32'(if4.res_err), 32'(err));
  endtask

  initial begin
    rst_n = 1'b0;
    if4.start = 1'b0; if4.out_valid = 1'b0; if4.out_addr = '0; if4.out_data = '0;
    if4.net_ack = 1'b0; if4.res_ack = 1'b0;
    if1.start = 1'b0; if1.out_valid = 1'b0; if1.out_addr = '0; if1.out_data = '0;
    if1.net_ack = 1'b0; if1.res_ack = 1'b0;
    #12;
    check_eq("rst_valid", 32'(if4.res_valid), 32'd0);
    check_eq("rst_busy", 32'(if4.busy), 32'd0);
    res4("rst", 3'd0, 8'sd0, 1'b0);
    check_eq("rst1_valid", 32'(if1.res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic argmax.
    load4(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 8'sd5, -8'sd3, 8'sd12, 8'sd7, 8'sd0);
    infer4(4, 1'b0, "t1");
    res4("t1", 3'd2, 8'sd12, 1'b0);
    ack4("t1");
    check_eq("t1_class_hold", 32'(if4.res_class), 32'd2);

    // Ties keep the earlier index; most negative value still becomes best.
    load4(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, -8'sd8, -8'sd8, -8'sd20, -8'sd9, 8'sd0);
    infer4(4, 1'b0, "t2a");
    res4("t2a", 3'd0, -8'sd8, 1'b0);
    ack4("t2a");
    load4(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, -8'sd128, -8'sd128, -8'sd128, -8'sd128, 8'sd0);
    infer4(4, 1'b0, "t2b");
    res4("t2b", 3'd0, -8'sd128, 1'b0);
    ack4("t2b");

    // Last value arrives together with net_ack and must still count.
    load4(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 8'sd1, 8'sd2, 8'sd3, 8'sd9, 8'sd0);
    infer4(4, 1'b1, "tmerge");
    res4("tmerge", 3'd3, 8'sd9, 1'b0);
    ack4("tmerge");

    // Threshold classifier.
    infer1(8'sd0, 1'b1, "t3a");
    infer1(-8'sd1, 1'b0, "t3b");
    infer1(8'sd127, 1'b1, "t3c");
    infer1(-8'sd128, 1'b0, "t3d");

    // Missing address.
    load4(3'd0, 3'd1, 3'd3, 3'd0, 3'd0, 8'sd1, 8'sd2, 8'sd3, 8'sd0, 8'sd0);
    infer4(3, 1'b0, "t4a");
    res4("t4a", 3'd3, 8'sd3, 1'b1);
    ack4("t4a");
    // Duplicate address: its data must be ignored.
    load4(3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 8'sd1, 8'sd2, 8'sd90, 8'sd3, 8'sd4);
    infer4(5, 1'b0, "t4b");
    res4("t4b", 3'd3, 8'sd4, 1'b1);
    ack4("t4b");
    // Out-of-range address: its data must be ignored.
    load4(3'd0, 3'd1, 3'd5, 3'd2, 3'd3, 8'sd1, 8'sd2, 8'sd90, 8'sd3, 8'sd4);
    infer4(5, 1'b0, "t4c");
    res4("t4c", 3'd3, 8'sd4, 1'b1);
    ack4("t4c");

    // Result holds in DONE despite out_valid traffic.
    load4(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 8'sd3, 8'sd9, 8'sd1, 8'sd4, 8'sd0);
    infer4(4, 1'b0, "t5");
    for (int i = 0; i < 10; i++) begin
      drive4(1'b0, 1'b1, 3'(i % 4), 8'sd100, 1'b0, 1'b0);
    end
    drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    check_eq("t5_valid_hold", 32'(if4.res_valid), 32'd1);
    res4("t5_hold", 3'd1, 8'sd9, 1'b0);
    drive4(1'b1, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    check_eq("t5_restart_valid", 32'(if4.res_valid), 32'd0);
    check_eq("t5_restart_busy", 32'(if4.busy), 32'd1);

    // Asynchronous reset mid-collection.
    drive4(1'b0, 1'b1, 3'd0, 8'sd100, 1'b0, 1'b0);
    drive4(1'b0, 1'b1, 3'd2, 8'sd50, 1'b0, 1'b0);
    drive4(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_busy", 32'(if4.busy), 32'd0);
    check_eq("t6_valid", 32'(if4.res_valid), 32'd0);
    res4("t6_rst", 3'd0, 8'sd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    load4(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd0);
    infer4(4, 1'b0, "t6");
    res4("t6", 3'd3, 8'sd4, 1'b0);
    ack4("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
